// File: rtl/riscv_wb_pkg.sv
// ---------------------------------------------------------------------------
// riscv_wb_pkg
// Shared definitions for the write-back / trap retire stage:
//   - RISC-V major opcodes that produce a register-file write
//   - mcause exception and interrupt codes (low bits only; the interrupt
//     flag in bit XLEN-1 is added by the priority encoder)
//   - retire FSM state type
// ---------------------------------------------------------------------------
package riscv_wb_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam int CAUSE_CODE_W = 4;

    localparam logic [CAUSE_CODE_W-1:0] CAUSE_INSTR_MISALIGNED   = 4'd0;
    localparam logic [CAUSE_CODE_W-1:0] CAUSE_INSTR_ACCESS_FAULT = 4'd1;
    localparam logic [CAUSE_CODE_W-1:0] CAUSE_ILLEGAL_INSTR      = 4'd2;
    localparam logic [CAUSE_CODE_W-1:0] CAUSE_LOAD_MISALIGNED    = 4'd4;
    localparam logic [CAUSE_CODE_W-1:0] CAUSE_LOAD_ACCESS_FAULT  = 4'd5;
    localparam logic [CAUSE_CODE_W-1:0] CAUSE_STORE_MISALIGNED   = 4'd6;
    localparam logic [CAUSE_CODE_W-1:0] CAUSE_STORE_ACCESS_FAULT = 4'd7;
    localparam logic [CAUSE_CODE_W-1:0] CAUSE_ECALL_U            = 4'd8;
    localparam logic [CAUSE_CODE_W-1:0] CAUSE_ECALL_M            = 4'd11;
    localparam logic [CAUSE_CODE_W-1:0] CAUSE_TIMER_INT          = 4'd7;
    localparam logic [CAUSE_CODE_W-1:0] CAUSE_EXTERNAL_INT       = 4'd11;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } wb_state_t;

endpackage

// File: rtl/trap_prio_enc.sv
// ---------------------------------------------------------------------------
// trap_prio_enc
// Combinational fixed-priority selector over the ten trap sources.
// Interrupts are only considered when mie is set and always win over
// synchronous exceptions.
// Ports:
//   ecall, f_iam, f_iaf, f_ii, mem_lam, mem_laf, mem_sam, mem_saf : exceptions
//   timer, external : interrupt requests
//   privilege       : 1 = M-mode (selects ecall cause 11 vs 8)
//   mie             : global interrupt enable
//   take            : some trap source is active
//   cause [XLEN]    : mcause value, bit XLEN-1 set for interrupts
// ---------------------------------------------------------------------------
module trap_prio_enc
    import riscv_wb_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            ecall,
    input  logic            f_iam,
    input  logic            f_iaf,
    input  logic            f_ii,
    input  logic            mem_lam,
    input  logic            mem_laf,
    input  logic            mem_sam,
    input  logic            mem_saf,
    input  logic            timer,
    input  logic            external,
    input  logic            privilege,
    input  logic            mie,
    output logic            take,
    output logic [XLEN-1:0] cause
);

    logic [CAUSE_CODE_W-1:0] code;
    logic                    is_irq;

    // Priority chain, highest first; the final else means nothing fired.
    always_comb begin
        take   = 1'b1;
        code   = '0;
        is_irq = 1'b0;
        if (mie && external) begin
            code   = CAUSE_EXTERNAL_INT;
            is_irq = 1'b1;
        end else if (mie && timer) begin
            code   = CAUSE_TIMER_INT;
            is_irq = 1'b1;
        end else if (f_iaf) begin
            code = CAUSE_INSTR_ACCESS_FAULT;
        end else if (f_ii) begin
            code = CAUSE_ILLEGAL_INSTR;
        end else if (f_iam) begin
            code = CAUSE_INSTR_MISALIGNED;
        end else if (ecall) begin
            code = privilege ? CAUSE_ECALL_M : CAUSE_ECALL_U;
        end else if (mem_sam) begin
            code = CAUSE_STORE_MISALIGNED;
        end else if (mem_lam) begin
            code = CAUSE_LOAD_MISALIGNED;
        end else if (mem_saf) begin
            code = CAUSE_STORE_ACCESS_FAULT;
        end else if (mem_laf) begin
            code = CAUSE_LOAD_ACCESS_FAULT;
        end else begin
            take = 1'b0;
        end

        cause                    = '0;
        cause[CAUSE_CODE_W-1:0]  = code;
        cause[XLEN-1]            = is_irq;
    end

endmodule

// File: rtl/wb_trap_retire.sv
// ---------------------------------------------------------------------------
// wb_trap_retire
// Write-back / retire stage with trap handling. Each accepted instruction
// produces registered results one cycle later: either a register-file /
// CSR write strobe, or (on a trap) a one-cycle context-switch pulse with
// CAUSE/EPC and a redirect to TVEC, followed by FLUSH_CYCLES cycles in
// which write-back is squashed and BUSY is high.
//
// Parameters: XLEN (data width), FLUSH_CYCLES (1..15 squash cycles).
// Inputs : CLK, RESET (async, active high), WB_V, WB_IR, WB_DRID,
//          WB_NPC, WB_MEM_RESULT, WB_ALU_RESULT, WB_RFD, WB_CSRFD,
//          WB_PC_MUX, TVEC, MIE, PRIVILEGE, exception and interrupt bits.
// Outputs: WB_RF_DATA, WB_CSR_DATA, WB_DRID_OUT, WB_LD_REG, WB_LD_CSR,
//          PC_MUX, WB_BR_JMP_TARGET, CS, CAUSE, EPC, BUSY (all registered).
// Optional: define WB_INSTRET_CNT_EN to add the INSTRET retire counter.
// ---------------------------------------------------------------------------
module wb_trap_retire
    import riscv_wb_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            WB_V,
    input  logic [31:0]     WB_IR,
    input  logic [4:0]      WB_DRID,
    input  logic [XLEN-1:0] WB_NPC,
    input  logic [XLEN-1:0] WB_MEM_RESULT,
    input  logic [XLEN-1:0] WB_ALU_RESULT,
    input  logic [XLEN-1:0] WB_RFD,
    input  logic [XLEN-1:0] WB_CSRFD,
    input  logic            WB_PC_MUX,
    input  logic [XLEN-1:0] TVEC,
    input  logic            MIE,
    input  logic            PRIVILEGE,
    input  logic            WB_ECALL,
    input  logic            F_IAM,
    input  logic            F_IAF,
    input  logic            F_II,
    input  logic            MEM_LAM,
    input  logic            MEM_LAF,
    input  logic            MEM_SAM,
    input  logic            MEM_SAF,
    input  logic            TIMER,
    input  logic            EXTERNAL,
    output logic [XLEN-1:0] WB_RF_DATA,
    output logic [XLEN-1:0] WB_CSR_DATA,
    output logic [4:0]      WB_DRID_OUT,
    output logic            WB_LD_REG,
    output logic            WB_LD_CSR,
    output logic            PC_MUX,
    output logic [XLEN-1:0] WB_BR_JMP_TARGET,
    output logic            CS,
    output logic [XLEN-1:0] CAUSE,
    output logic [XLEN-1:0] EPC,
`ifdef WB_INSTRET_CNT_EN
    output logic [XLEN-1:0] INSTRET,
`endif
    output logic            BUSY
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    wb_state_t       state;
    logic [3:0]      flush_cnt;

    logic            take;
    logic [XLEN-1:0] trap_cause;

    logic            ld_reg_d;
    logic            ld_csr_d;
    logic [XLEN-1:0] rf_data_d;

    // Only the opcode field matters here; the rest of the instruction word
    // is decoded upstream.
    logic            unused_ir_bits;
    assign unused_ir_bits = ^WB_IR[31:7];

    trap_prio_enc #(
        .XLEN(XLEN)
    ) u_prio (
        .ecall    (WB_ECALL),
        .f_iam    (F_IAM),
        .f_iaf    (F_IAF),
        .f_ii     (F_II),
        .mem_lam  (MEM_LAM),
        .mem_laf  (MEM_LAF),
        .mem_sam  (MEM_SAM),
        .mem_saf  (MEM_SAF),
        .timer    (TIMER),
        .external (EXTERNAL),
        .privilege(PRIVILEGE),
        .mie      (MIE),
        .take     (take),
        .cause    (trap_cause)
    );

    // Result-source selection by opcode; writes to x0 are dropped but a
    // SYSTEM instruction still writes its CSR.
    always_comb begin
        ld_reg_d  = 1'b0;
        ld_csr_d  = 1'b0;
        rf_data_d = WB_ALU_RESULT;
        case (WB_IR[6:0])
            OPC_LOAD: begin
                ld_reg_d  = 1'b1;
                rf_data_d = WB_MEM_RESULT;
            end
            OPC_OP_IMM, OPC_OP, OPC_LUI, OPC_AUIPC: begin
                ld_reg_d  = 1'b1;
                rf_data_d = WB_ALU_RESULT;
            end
            OPC_SYSTEM: begin
                ld_reg_d  = 1'b1;
                ld_csr_d  = 1'b1;
                rf_data_d = WB_RFD;
            end
            OPC_JALR, OPC_JAL: begin
                ld_reg_d  = 1'b1;
                rf_data_d = WB_NPC;
            end
            default: begin
                ld_reg_d = 1'b0;
            end
        endcase
        if (WB_DRID == 5'd0) begin
            ld_reg_d = 1'b0;
        end
    end

    // Retire FSM with registered outputs. Strobes default low every cycle;
    // the flush counter is loaded on a trap and returns to RUN on the edge
    // where it would reach zero, so the following edge can accept again.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state            <= ST_RUN;
            flush_cnt        <= '0;
            WB_RF_DATA       <= '0;
            WB_CSR_DATA      <= '0;
            WB_DRID_OUT      <= '0;
            WB_LD_REG        <= 1'b0;
            WB_LD_CSR        <= 1'b0;
            PC_MUX           <= 1'b0;
            WB_BR_JMP_TARGET <= '0;
            CS               <= 1'b0;
            CAUSE            <= '0;
            EPC              <= '0;
            BUSY             <= 1'b0;
`ifdef WB_INSTRET_CNT_EN
            INSTRET          <= '0;
`endif
        end else begin
            WB_LD_REG <= 1'b0;
            WB_LD_CSR <= 1'b0;
            PC_MUX    <= 1'b0;
            CS        <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (WB_V) begin
                        if (take) begin
                            CS               <= 1'b1;
                            CAUSE            <= trap_cause;
                            EPC              <= WB_NPC - XLEN'(4);
                            PC_MUX           <= 1'b1;
                            WB_BR_JMP_TARGET <= TVEC;
                            BUSY             <= 1'b1;
                            flush_cnt        <= FLUSH_LOAD;
                            state            <= ST_FLUSH;
                        end else begin
                            WB_LD_REG        <= ld_reg_d;
                            WB_LD_CSR        <= ld_csr_d;
                            WB_RF_DATA       <= rf_data_d;
                            WB_CSR_DATA      <= WB_CSRFD;
                            WB_DRID_OUT      <= WB_DRID;
                            PC_MUX           <= WB_PC_MUX;
                            WB_BR_JMP_TARGET <= WB_ALU_RESULT;
`ifdef WB_INSTRET_CNT_EN
                            INSTRET          <= INSTRET + XLEN'(1);
`endif
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt <= 4'd1) begin
                        flush_cnt <= '0;
                        BUSY      <= 1'b0;
                        state     <= ST_RUN;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_trap_retire.sv
// ---------------------------------------------------------------------------
// tb_wb_trap_retire
// Self-checking bench for wb_trap_retire: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model. Define WB_INSTRET_CNT_EN to also check INSTRET.
// ---------------------------------------------------------------------------
module tb_wb_trap_retire;

    localparam int XLEN         = 64;
    localparam int FLUSH_CYCLES = 3;

    logic            CLK = 1'b0;
    logic            RESET = 1'b0;
    logic            WB_V;
    logic [31:0]     WB_IR;
    logic [4:0]      WB_DRID;
    logic [XLEN-1:0] WB_NPC, WB_MEM_RESULT, WB_ALU_RESULT, WB_RFD, WB_CSRFD, TVEC;
    logic            WB_PC_MUX, MIE, PRIVILEGE;
    logic            WB_ECALL, F_IAM, F_IAF, F_II, MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF;
    logic            TIMER, EXTERNAL;

    logic [XLEN-1:0] WB_RF_DATA, WB_CSR_DATA, WB_BR_JMP_TARGET, CAUSE, EPC;
    logic [4:0]      WB_DRID_OUT;
    logic            WB_LD_REG, WB_LD_CSR, PC_MUX, CS, BUSY;
`ifdef WB_INSTRET_CNT_EN
    logic [XLEN-1:0] INSTRET;
`endif

    wb_trap_retire #(
        .XLEN(XLEN),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .CLK(CLK), .RESET(RESET), .WB_V(WB_V), .WB_IR(WB_IR), .WB_DRID(WB_DRID),
        .WB_NPC(WB_NPC), .WB_MEM_RESULT(WB_MEM_RESULT), .WB_ALU_RESULT(WB_ALU_RESULT),
        .WB_RFD(WB_RFD), .WB_CSRFD(WB_CSRFD), .WB_PC_MUX(WB_PC_MUX), .TVEC(TVEC),
        .MIE(MIE), .PRIVILEGE(PRIVILEGE), .WB_ECALL(WB_ECALL), .F_IAM(F_IAM),
        .F_IAF(F_IAF), .F_II(F_II), .MEM_LAM(MEM_LAM), .MEM_LAF(MEM_LAF),
        .MEM_SAM(MEM_SAM), .MEM_SAF(MEM_SAF), .TIMER(TIMER), .EXTERNAL(EXTERNAL),
        .WB_RF_DATA(WB_RF_DATA), .WB_CSR_DATA(WB_CSR_DATA), .WB_DRID_OUT(WB_DRID_OUT),
        .WB_LD_REG(WB_LD_REG), .WB_LD_CSR(WB_LD_CSR), .PC_MUX(PC_MUX),
        .WB_BR_JMP_TARGET(WB_BR_JMP_TARGET), .CS(CS), .CAUSE(CAUSE), .EPC(EPC),
`ifdef WB_INSTRET_CNT_EN
        .INSTRET(INSTRET),
`endif
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int n_compared = 0;
    int n_mismatch = 0;

    task automatic checkOutput(input string name, input logic [XLEN-1:0] act,
                               input logic [XLEN-1:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model: what the stage must show after each clock edge.
    // -----------------------------------------------------------------------
    logic [XLEN-1:0] m_rf, m_csr, m_target, m_cause, m_epc, m_instret;
    logic [4:0]      m_drid;
    logic            m_ld_reg, m_ld_csr, m_pc_mux, m_cs, m_busy, m_acc;
    int              flush_left;
    bit              src[10];
    int              num[10];
    bit              hit;
    logic [XLEN-1:0] code;

    initial begin
        m_rf = '0; m_csr = '0; m_target = '0; m_cause = '0; m_epc = '0; m_instret = '0;
        m_drid = '0; m_ld_reg = 0; m_ld_csr = 0; m_pc_mux = 0; m_cs = 0; m_busy = 0;
        m_acc = 0; flush_left = 0;
    end

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_rf = '0; m_csr = '0; m_target = '0; m_cause = '0; m_epc = '0; m_instret = '0;
            m_drid = '0; m_ld_reg = 0; m_ld_csr = 0; m_pc_mux = 0; m_cs = 0; m_busy = 0;
            m_acc = 0; flush_left = 0;
        end else begin
            m_ld_reg = 0; m_ld_csr = 0; m_pc_mux = 0; m_cs = 0; m_acc = 0;
            if (flush_left > 0) begin
                flush_left--;
                m_busy = (flush_left > 0);
            end else if (WB_V) begin
                m_acc = 1;
                src = '{MIE && EXTERNAL, MIE && TIMER, F_IAF, F_II, F_IAM, WB_ECALL,
                        MEM_SAM, MEM_LAM, MEM_SAF, MEM_LAF};
                num = '{11, 7, 1, 2, 0, (PRIVILEGE ? 11 : 8), 6, 4, 7, 5};
                hit = 0;
                code = '0;
                for (int i = 0; i < 10; i++) begin
                    if (!hit && src[i]) begin
                        hit = 1;
                        code = XLEN'(num[i]);
                        if (i < 2) code = code + (64'd1 << (XLEN - 1));
                    end
                end
                if (hit) begin
                    m_cs = 1; m_cause = code; m_epc = WB_NPC - 64'd4;
                    m_pc_mux = 1; m_target = TVEC;
                    flush_left = FLUSH_CYCLES; m_busy = 1;
                end else begin
                    m_pc_mux = WB_PC_MUX;
                    m_target = WB_ALU_RESULT;
                    m_drid = WB_DRID;
                    m_csr = WB_CSRFD;
                    m_instret = m_instret + 64'd1;
                    case (WB_IR[6:0])
                        7'b0000011: begin m_ld_reg = 1; m_rf = WB_MEM_RESULT; end
                        7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111:
                            begin m_ld_reg = 1; m_rf = WB_ALU_RESULT; end
                        7'b1110011: begin m_ld_reg = 1; m_ld_csr = 1; m_rf = WB_RFD; end
                        7'b1100111, 7'b1101111: begin m_ld_reg = 1; m_rf = WB_NPC; end
                        default: m_ld_reg = 0;
                    endcase
                    if (WB_DRID == 5'd0) m_ld_reg = 0;
                end
            end
        end
    end

    // Compare process: outputs are settled mid-cycle.
    always @(negedge CLK) begin
        if (!RESET) begin
            checkOutput("busy", XLEN'(BUSY), XLEN'(m_busy));
            checkOutput("cs", XLEN'(CS), XLEN'(m_cs));
            checkOutput("pc_mux", XLEN'(PC_MUX), XLEN'(m_pc_mux));
            checkOutput("ld_reg", XLEN'(WB_LD_REG), XLEN'(m_ld_reg));
            checkOutput("ld_csr", XLEN'(WB_LD_CSR), XLEN'(m_ld_csr));
            checkOutput("cause", CAUSE, m_cause);
            checkOutput("epc", EPC, m_epc);
            if (m_acc) checkOutput("target", WB_BR_JMP_TARGET, m_target);
            if (m_ld_reg) begin
                checkOutput("rf_data", WB_RF_DATA, m_rf);
                checkOutput("drid_out", XLEN'(WB_DRID_OUT), XLEN'(m_drid));
            end
            if (m_ld_csr) checkOutput("csr_data", WB_CSR_DATA, m_csr);
`ifdef WB_INSTRET_CNT_EN
            checkOutput("instret", INSTRET, m_instret);
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic idleInputs();
        WB_V = 0; WB_IR = 32'h0; WB_DRID = 5'd0;
        WB_NPC = '0; WB_MEM_RESULT = '0; WB_ALU_RESULT = '0; WB_RFD = '0; WB_CSRFD = '0;
        TVEC = '0; WB_PC_MUX = 0; MIE = 0; PRIVILEGE = 0;
        WB_ECALL = 0; F_IAM = 0; F_IAF = 0; F_II = 0;
        MEM_LAM = 0; MEM_LAF = 0; MEM_SAM = 0; MEM_SAF = 0; TIMER = 0; EXTERNAL = 0;
    endtask

    // Advance one clock and land just after the edge.
    task automatic applyStimulus();
        @(posedge CLK);
        #1;
    endtask

    task automatic randomInputs();
        logic [6:0] ops [10];
        ops = '{7'b0000011, 7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111,
                7'b1110011, 7'b1100111, 7'b1101111, 7'b0100011, 7'b1100011};
        WB_V = ($urandom_range(0, 3) != 0);
        WB_IR = $urandom;
        WB_IR[6:0] = ops[$urandom_range(0, 9)];
        WB_DRID = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        WB_NPC = {$urandom, $urandom};
        WB_MEM_RESULT = {$urandom, $urandom};
        WB_ALU_RESULT = {$urandom, $urandom};
        WB_RFD = {$urandom, $urandom};
        WB_CSRFD = {$urandom, $urandom};
        TVEC = {$urandom, $urandom};
        WB_PC_MUX = 1'($urandom);
        MIE = 1'($urandom);
        PRIVILEGE = 1'($urandom);
        WB_ECALL = ($urandom_range(0, 19) == 0);
        F_IAM = ($urandom_range(0, 19) == 0);
        F_IAF = ($urandom_range(0, 19) == 0);
        F_II = ($urandom_range(0, 19) == 0);
        MEM_LAM = ($urandom_range(0, 19) == 0);
        MEM_LAF = ($urandom_range(0, 19) == 0);
        MEM_SAM = ($urandom_range(0, 19) == 0);
        MEM_SAF = ($urandom_range(0, 19) == 0);
        TIMER = ($urandom_range(0, 9) == 0);
        EXTERNAL = ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        idleInputs();
        #2 RESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        $display("[TB] reset state");
        checkOutput("rst_busy", XLEN'(BUSY), '0);
        checkOutput("rst_cs", XLEN'(CS), '0);
        checkOutput("rst_ld_reg", XLEN'(WB_LD_REG), '0);
        checkOutput("rst_cause", CAUSE, '0);
        checkOutput("rst_epc", EPC, '0);

        // Load retire accepted on the first edge after reset release.
        WB_V = 1; WB_IR = 32'h0000_0003; WB_DRID = 5'd5; WB_MEM_RESULT = 64'hDEAD;
        WB_ALU_RESULT = 64'h1234;
        RESET = 1'b0;
        applyStimulus();
        checkOutput("load_rf", WB_RF_DATA, 64'hDEAD);
        checkOutput("load_drid", XLEN'(WB_DRID_OUT), 64'd5);
        checkOutput("load_ld", XLEN'(WB_LD_REG), 64'd1);
        idleInputs();
        applyStimulus();
        checkOutput("load_strobe_end", XLEN'(WB_LD_REG), 64'd0);

        // Write to x0 is dropped, then the same op to x3 is kept.
        WB_V = 1; WB_IR = 32'h0000_0013; WB_DRID = 5'd0; WB_ALU_RESULT = 64'h55;
        applyStimulus();
        checkOutput("x0_ld", XLEN'(WB_LD_REG), 64'd0);
        WB_DRID = 5'd3;
        applyStimulus();
        checkOutput("x3_ld", XLEN'(WB_LD_REG), 64'd1);
        checkOutput("x3_rf", WB_RF_DATA, 64'h55);

        // SYSTEM writes both register and CSR.
        WB_IR = 32'h0000_0073; WB_DRID = 5'd2; WB_RFD = 64'h11; WB_CSRFD = 64'h22;
        applyStimulus();
        checkOutput("sys_ld_csr", XLEN'(WB_LD_CSR), 64'd1);
        checkOutput("sys_csr", WB_CSR_DATA, 64'h22);
        checkOutput("sys_rf", WB_RF_DATA, 64'h11);

        // JAL with taken redirect.
        WB_IR = 32'h0000_006F; WB_NPC = 64'h3000; WB_ALU_RESULT = 64'h4444; WB_PC_MUX = 1;
        applyStimulus();
        checkOutput("jal_rf", WB_RF_DATA, 64'h3000);
        checkOutput("jal_pc_mux", XLEN'(PC_MUX), 64'd1);
        checkOutput("jal_target", WB_BR_JMP_TARGET, 64'h4444);

        // Simultaneous exceptions: illegal instruction wins over load fault.
        idleInputs();
        WB_V = 1; WB_IR = 32'h0000_0033; WB_DRID = 5'd7; F_II = 1; MEM_LAF = 1;
        WB_NPC = 64'h1004; TVEC = 64'h8000;
        applyStimulus();
        checkOutput("trap_cs", XLEN'(CS), 64'd1);
        checkOutput("trap_cause", CAUSE, 64'd2);
        checkOutput("trap_epc", EPC, 64'h1000);
        checkOutput("trap_pc_mux", XLEN'(PC_MUX), 64'd1);
        checkOutput("trap_target", WB_BR_JMP_TARGET, 64'h8000);
        checkOutput("trap_ld_reg", XLEN'(WB_LD_REG), 64'd0);
        checkOutput("trap_busy", XLEN'(BUSY), 64'd1);
        idleInputs();
        applyStimulus();
        checkOutput("trap_cs_pulse", XLEN'(CS), 64'd0);
        applyStimulus();
        applyStimulus();
        checkOutput("trap_busy_end", XLEN'(BUSY), 64'd0);

        // Interrupt priority, then flush with WB_V held high.
        WB_V = 1; WB_IR = 32'h0000_0033; WB_DRID = 5'd1;
        MIE = 1; TIMER = 1; EXTERNAL = 1; WB_ECALL = 1;
        applyStimulus();
        checkOutput("irq_cause", CAUSE, 64'h8000_0000_0000_000B);
        checkOutput("irq_cs", XLEN'(CS), 64'd1);
        TIMER = 0; EXTERNAL = 0; WB_ECALL = 0;
        WB_IR = 32'h0000_0003; WB_DRID = 5'd9; WB_MEM_RESULT = 64'h77;
        for (int k = 1; k <= 3; k++) begin
            applyStimulus();
            checkOutput("flush_ld_reg", XLEN'(WB_LD_REG), 64'd0);
            checkOutput("flush_busy", XLEN'(BUSY), (k < 3) ? 64'd1 : 64'd0);
        end
        applyStimulus();
        checkOutput("post_flush_ld", XLEN'(WB_LD_REG), 64'd1);
        checkOutput("post_flush_rf", WB_RF_DATA, 64'h77);
        checkOutput("cause_held", CAUSE, 64'h8000_0000_0000_000B);

        // Masked timer interrupt retires normally.
        idleInputs();
        WB_V = 1; WB_IR = 32'h0000_0013; WB_DRID = 5'd4; WB_ALU_RESULT = 64'h99;
        MIE = 0; TIMER = 1;
        applyStimulus();
        checkOutput("masked_cs", XLEN'(CS), 64'd0);
        checkOutput("masked_ld", XLEN'(WB_LD_REG), 64'd1);

        // U-mode ecall at NPC=0: EPC wraps.
        idleInputs();
        WB_V = 1; WB_ECALL = 1; PRIVILEGE = 0; WB_NPC = 64'd0;
        applyStimulus();
        checkOutput("ecall_cause", CAUSE, 64'd8);
        checkOutput("ecall_epc", EPC, 64'hFFFF_FFFF_FFFF_FFFC);
        idleInputs();
        repeat (3) applyStimulus();

        // Reset in the second flush cycle.
        WB_V = 1; F_IAM = 1; WB_NPC = 64'h2000;
        applyStimulus();
        idleInputs();
        applyStimulus();
        checkOutput("pre_rst_busy", XLEN'(BUSY), 64'd1);
        RESET = 1'b1;
        #1;
        checkOutput("midrst_busy", XLEN'(BUSY), 64'd0);
        checkOutput("midrst_cause", CAUSE, 64'd0);
        applyStimulus();
        WB_V = 1; WB_IR = 32'h0000_0013; WB_DRID = 5'd6; WB_ALU_RESULT = 64'hAB;
        RESET = 1'b0;
        applyStimulus();
        checkOutput("after_rst_ld", XLEN'(WB_LD_REG), 64'd1);
        checkOutput("after_rst_rf", WB_RF_DATA, 64'hAB);

        // Randomized traffic, occasionally interrupted by reset.
        $display("[TB] random phase");
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                RESET = 1'b1;
                applyStimulus();
                RESET = 1'b0;
            end
            randomInputs();
            applyStimulus();
        end
        idleInputs();
        repeat (4) applyStimulus();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule

// File: doc/wb_trap_retire.md
WB_TRAP_RETIRE -- requirements
Module: wb_trap_retire

Interface
REQ-001 SHALL have parameter XLEN, default 64: data/address width.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 3: cycles writes are squashed after a trap; legal range 1..15.
REQ-003 SHALL have ports: CLK in 1, clock (rising edge); RESET in 1, asynchronous active-high reset.
REQ-004 SHALL have inputs:
- WB_V 1, instruction valid.
- WB_IR 32, instruction.
- WB_DRID 5, destination register.
- WB_NPC, WB_MEM_RESULT, WB_ALU_RESULT, WB_RFD, WB_CSRFD, all XLEN, result sources.
- WB_PC_MUX 1, branch/jump taken.
- TVEC XLEN, trap vector.
- MIE 1, global interrupt enable.
- PRIVILEGE 1, 1 = M-mode, 0 = U-mode.
REQ-005 SHALL have 1-bit exception inputs: WB_ECALL, F_IAM, F_IAF, F_II, MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF; and 1-bit interrupt inputs: TIMER, EXTERNAL.
REQ-006 SHALL have registered outputs:
- WB_RF_DATA XLEN.
- WB_CSR_DATA XLEN.
- WB_DRID_OUT 5.
- WB_LD_REG 1.
- WB_LD_CSR 1.
- PC_MUX 1.
- WB_BR_JMP_TARGET XLEN.
- CS 1, trap context switch.
- CAUSE XLEN.
- EPC XLEN, PC of the trapping instruction (NPC-4).
- BUSY 1, high while flushing.

Function
REQ-007 SHALL produce every output one cycle after the accepted input (latency 1).
REQ-008 SHALL select the register-file write by WB_IR[6:0] when WB_V is high in RUN:
- 0000011: MEM_RESULT.
- 0010011, 0110011, 0110111, 0010111: ALU_RESULT.
- 1110011: RFD, and also CSRFD with LD_CSR=1.
- 1100111, 1101111: NPC.
- Any other opcode: LD_REG=0.
REQ-009 SHALL force LD_REG=0 when WB_DRID==0.
REQ-010 SHALL drive WB_LD_REG and WB_LD_CSR as single-cycle strobes, 0 in any cycle without an accepted retire.
REQ-011 SHALL, on every accepted instruction, set PC_MUX=WB_PC_MUX and BR_JMP_TARGET=ALU_RESULT; otherwise PC_MUX=0.
REQ-012 SHALL detect a trap when WB_V is high in RUN and any exception is asserted, or MIE is high with TIMER or EXTERNAL asserted.
REQ-013 SHALL apply fixed priority, highest first; CAUSE[XLEN-1]=1 for interrupts:
- EXTERNAL: 11, interrupt.
- TIMER: 7, interrupt.
- F_IAF: 1.
- F_II: 2.
- F_IAM: 0.
- ECALL: 11 if PRIVILEGE else 8.
- MEM_SAM: 6.
- MEM_LAM: 4.
- MEM_SAF: 7.
- MEM_LAF: 5.
REQ-014 SHALL, on a trap:
- Suppress LD_REG and LD_CSR for that instruction.
- Pulse CS for exactly one cycle.
- Register CAUSE and set EPC=WB_NPC-4.
- Drive PC_MUX=1 with BR_JMP_TARGET=TVEC.
REQ-015 SHALL implement FSM RUN -> FLUSH on trap; FLUSH -> RUN after FLUSH_CYCLES cycles counted by a 4-bit down-counter.
REQ-016 SHALL, in FLUSH, ignore WB_V and all trap inputs, hold BUSY=1, and keep LD_REG=LD_CSR=CS=PC_MUX=0.
REQ-017 SHALL accept the first WB_V in the cycle FLUSH returns to RUN.
REQ-018 SHALL hold CAUSE and EPC until the next trap.
REQ-019 SHALL perform NPC-4 modulo 2^XLEN; NPC=0 gives EPC all-ones minus 3.

Reset
REQ-020 SHALL, on RESET assertion, immediately set state=RUN, counter=0 and all outputs=0, including mid-FLUSH.
REQ-021 SHALL accept nothing while RESET is high and accept WB_V on the first rising edge after deassertion.

Configuration
REQ-022 SHALL support macro WB_INSTRET_CNT_EN:
- Defined: adds output INSTRET (XLEN, reset 0), incremented on each non-trapping accepted retire and wrapping from all-ones to 0.
- Undefined: port and counter are absent and all other behaviour is identical.

Structure
REQ-023 SHALL place opcode constants, cause-code constants and the FSM state typedef in shared package riscv_wb_pkg.
REQ-024 SHALL implement priority selection as combinational sub-module trap_prio_enc, with inputs the ten trap bits plus PRIVILEGE and MIE, and outputs take and cause.

Verification
REQ-025 SHALL cover load retire: WB_V=1, IR opcode 0000011, DRID=5, MEM_RESULT=0xDEAD -> next cycle RF_DATA=0xDEAD, DRID_OUT=5, LD_REG=1 for one cycle.
REQ-026 SHALL cover write to x0: ALU op with DRID=0 -> LD_REG=0.
REQ-027 SHALL cover simultaneous traps: F_II=1 and MEM_LAF=1, NPC=0x1004, TVEC=0x8000 -> CS pulse, CAUSE=2, EPC=0x1000, PC_MUX=1, target 0x8000, LD_REG=0.
REQ-028 SHALL cover interrupt priority: MIE=1, TIMER=1, EXTERNAL=1, ECALL=1 -> CAUSE=2^(XLEN-1)+11; then 3 cycles BUSY=1 with WB_V ignored, retire accepted on the 4th.
REQ-029 SHALL cover masked interrupt: MIE=0, TIMER=1 -> normal retire, CS=0.
REQ-030 SHALL cover reset mid-FLUSH: RESET asserted in the 2nd FLUSH cycle -> BUSY=0 immediately; WB_V accepted on the first edge after release.
